// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC ownership, credit-limited memory requests,
// in-order instruction buffer and redirect handling with wrong-path discard.
module instr_fetch_unit #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode,
    output logic [2:0]  id_funct3,
    output logic [6:0]  id_funct7
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] BOOT_PC   = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } state_t;

    state_t state, state_next;

    logic [31:0]   fetch_pc;
    logic [31:0]   push_pc;
    logic [31:0]   target_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] discard;
    logic [CW-1:0] discard_next;
    logic [CW-1:0] fifo_count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW:0]   occupancy;

    logic [31:0] pc_mem    [FIFO_DEPTH];
    logic [31:0] instr_mem [FIFO_DEPTH];

    logic fifo_empty;
    logic credit;
    logic transfer;
    logic resp;
    logic push;
    logic pop;
    logic unused_redirect_bits;

    assign target_pc            = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign fifo_empty = (fifo_count == '0);
    assign id_valid   = !fifo_empty && (state != BOOT) && !redirect_valid;
    assign pop        = id_valid && id_ready;

    // Credits count both buffered words and words still in flight, so a
    // response can never arrive to a full buffer.
    assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
    assign credit    = (occupancy < DEPTH_LIM);

    assign transfer = imem_req && imem_gnt;
    assign resp     = imem_rvalid && (outstanding != '0);
    assign push     = resp && (discard == '0) && !redirect_valid;

    assign outstanding_next = outstanding + CW'(transfer) - CW'(resp);

    always_comb begin
        discard_next = discard;
        if (redirect_valid) begin
            discard_next = outstanding_next;
        end else if (resp && (discard != '0)) begin
            discard_next = discard - CW'(1);
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        unique case (state)
            BOOT:  state_next = RUN;
            RUN:   imem_req   = credit;
            FLUSH: begin
                if (discard_next == '0) begin
                    state_next = RUN;
                end
            end
            default: state_next = BOOT;
        endcase
        if (redirect_valid) begin
            state_next = (outstanding_next != '0) ? FLUSH : RUN;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            fetch_pc    <= BOOT_PC;
            push_pc     <= BOOT_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            discard     <= discard_next;
            if (redirect_valid) begin
                fetch_pc <= target_pc;
                push_pc  <= target_pc;
            end else begin
                if (transfer) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    push_pc <= push_pc + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else if (redirect_valid) begin
            rd_ptr     <= wr_ptr;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: buffer storage has no reset; fifo_count alone says which
    // entries hold data, and the empty case is muxed to a NOP below.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

    assign imem_addr = fetch_pc;
    assign id_instr  = fifo_empty ? NOP_INSTR : instr_mem[rd_ptr];
    assign id_pc     = fifo_empty ? push_pc : pc_mem[rd_ptr];
    assign id_opcode = id_instr[6:0];
    assign id_funct3 = id_instr[14:12];
    assign id_funct7 = id_instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: memory model with programmable latency,
// directed fetch/redirect/reset scenarios, monitor compares each decode pop.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;

    instr_fetch_unit #(
        .FIFO_DEPTH(2),
        .RESET_PC  (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_opcode     (id_opcode),
        .id_funct3     (id_funct3),
        .id_funct7     (id_funct7)
    );

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    mem_req_t    pend[$];
    exp_t        exp_q[$];
    logic [31:0] gnt_addrs[$];
    mem_req_t    mem_r;
    exp_t        mon_e;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int lat       = 1;
    int gnt_count = 0;
    bit stray_req = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h0101_0101) ^ 32'h8C4B_2A73;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back('{pc, instr_of(pc)});
    endtask

    // Memory: responses are presented just after a rising edge, grants are
    // sampled mid-cycle once the DUT's combinational outputs have settled.
    always @(posedge clk) begin
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (stray_req) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            stray_req   = 1'b0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_r       = pend.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mem_r.addr);
        end
    end

    always @(negedge clk) begin
        #1;
        if (rst_n && imem_req && imem_gnt) begin
            pend.push_back('{cyc + lat, imem_addr});
            gnt_addrs.push_back(imem_addr);
            gnt_count++;
        end
    end

    // Monitor: every decode handshake must match the oldest expectation.
    always @(negedge clk) begin
        #1;
        if (rst_n && id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got pc %h instr %h, expected no instruction (cycle %0d)",
                         id_pc, id_instr, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("id_pc",     id_pc,     mon_e.pc);
                check("id_instr",  id_instr,  mon_e.instr);
                check("id_opcode", id_opcode, mon_e.instr[6:0]);
                check("id_funct3", id_funct3, mon_e.instr[14:12]);
                check("id_funct7", id_funct7, mon_e.instr[31:25]);
            end
        end
    end

    task automatic at_cycle(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (cyc != k && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("cycle_reached", cyc, k);
    endtask

    // Leaves the caller at the falling edge where reset is released (cycle 0).
    task automatic do_reset(input bit stray);
        @(negedge clk);
        rst_n          = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        pend.delete();
        #1;
        check("rst_req",      imem_req, 32'h0);
        check("rst_addr",     imem_addr, 32'h100);
        check("rst_valid",    id_valid, 32'h0);
        check("rst_instr",    id_instr, 32'h13);
        check("rst_pc",       id_pc, 32'h100);
        check("leftover_exp", exp_q.size(), 32'h0);
        exp_q.delete();
        @(negedge clk);
        stray_req = stray;
        @(negedge clk);
        rst_n = 1'b1;
        gnt_count = 0;
        gnt_addrs.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        imem_gnt       = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;

        // Streaming: 1-cycle memory, one instruction per cycle.
        do_reset(1'b0);
        id_ready = 1'b1;
        lat      = 1;
        for (int i = 0; i < 8; i++) push_exp(32'h100 + 32'(i * 4));
        #1;
        check("boot_req", imem_req, 32'h0);
        at_cycle(1); #1;
        check("s_req1",  imem_req, 32'h1);
        check("s_addr1", imem_addr, 32'h100);
        at_cycle(2); #1;
        check("s_addr2",  imem_addr, 32'h104);
        check("s_valid2", id_valid, 32'h0);
        at_cycle(3); #1;
        check("s_addr3",  imem_addr, 32'h108);
        check("s_valid3", id_valid, 32'h1);
        at_cycle(11);
        id_ready = 1'b0;
        #1;
        check("s_drained", exp_q.size(), 32'h0);

        // Back-pressure: decode stalled from the start.
        do_reset(1'b0);
        id_ready = 1'b0;
        lat      = 1;
        at_cycle(8); #1;
        check("bp_grants",  gnt_count, 32'd2);
        check("bp_gaddr0",  gnt_addrs[0], 32'h100);
        check("bp_gaddr1",  gnt_addrs[1], 32'h104);
        check("bp_req_low", imem_req, 32'h0);
        check("bp_valid",   id_valid, 32'h1);
        check("bp_head_pc", id_pc, 32'h100);
        check("bp_head_in", id_instr, instr_of(32'h100));
        push_exp(32'h100);
        push_exp(32'h104);
        push_exp(32'h108);
        at_cycle(9);
        id_ready = 1'b1;
        #1;
        check("bp_resume_req",  imem_req, 32'h1);
        check("bp_resume_addr", imem_addr, 32'h108);
        at_cycle(12);
        id_ready = 1'b0;
        #1;
        check("bp_drained", exp_q.size(), 32'h0);

        // Redirect with two requests in flight at latency 3.
        do_reset(1'b0);
        id_ready = 1'b1;
        lat      = 3;
        push_exp(32'h2000);
        push_exp(32'h2004);
        at_cycle(2); #1;
        check("fl_addr2", imem_addr, 32'h104);
        at_cycle(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000;
        #1;
        check("fl_req3", imem_req, 32'h0);
        at_cycle(4);
        redirect_valid = 1'b0;
        #1;
        check("fl_req4",   imem_req, 32'h0);
        check("fl_valid4", id_valid, 32'h0);
        at_cycle(5); #1;
        check("fl_req5",   imem_req, 32'h0);
        check("fl_valid5", id_valid, 32'h0);
        at_cycle(6); #1;
        check("fl_req6",  imem_req, 32'h1);
        check("fl_addr6", imem_addr, 32'h2000);
        at_cycle(9); #1;
        check("fl_valid9", id_valid, 32'h0);
        at_cycle(12);
        id_ready = 1'b0;
        #1;
        check("fl_drained", exp_q.size(), 32'h0);

        // Redirect coinciding with a response, a grant and id_ready.
        do_reset(1'b0);
        id_ready = 1'b1;
        lat      = 1;
        push_exp(32'h3000);
        push_exp(32'h3004);
        at_cycle(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000;
        #1;
        check("co_req2",    imem_req, 32'h1);
        check("co_addr2",   imem_addr, 32'h104);
        check("co_rvalid2", imem_rvalid, 32'h1);
        check("co_valid2",  id_valid, 32'h0);
        at_cycle(3);
        redirect_valid = 1'b0;
        #1;
        check("co_req3",   imem_req, 32'h0);
        check("co_valid3", id_valid, 32'h0);
        at_cycle(4); #1;
        check("co_req4",   imem_req, 32'h1);
        check("co_addr4",  imem_addr, 32'h3000);
        check("co_valid4", id_valid, 32'h0);
        at_cycle(5); #1;
        check("co_valid5", id_valid, 32'h0);
        at_cycle(8);
        id_ready = 1'b0;
        #1;
        check("co_drained", exp_q.size(), 32'h0);

        // Misaligned redirect target during BOOT, nothing outstanding.
        do_reset(1'b0);
        id_ready       = 1'b1;
        lat            = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2002;
        push_exp(32'h2000);
        push_exp(32'h2004);
        #1;
        check("al_valid0", id_valid, 32'h0);
        at_cycle(1);
        redirect_valid = 1'b0;
        #1;
        check("al_req1",  imem_req, 32'h1);
        check("al_addr1", imem_addr, 32'h2000);
        at_cycle(5);
        id_ready = 1'b0;
        #1;
        check("al_drained", exp_q.size(), 32'h0);

        // Address wrap at the top of the 32-bit space.
        do_reset(1'b0);
        id_ready       = 1'b1;
        lat            = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFD;
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0000_0000);
        at_cycle(1);
        redirect_valid = 1'b0;
        #1;
        check("wr_addr1", imem_addr, 32'hFFFF_FFFC);
        at_cycle(2); #1;
        check("wr_addr2", imem_addr, 32'h0000_0000);
        at_cycle(5);
        id_ready = 1'b0;
        #1;
        check("wr_drained", exp_q.size(), 32'h0);

        // Asynchronous reset with requests in flight, then a stray response.
        do_reset(1'b0);
        id_ready = 1'b0;
        lat      = 2;
        at_cycle(4); #1;
        check("ar_valid_pre", id_valid, 32'h1);
        check("ar_addr_pre",  imem_addr, 32'h108);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_req",   imem_req, 32'h0);
        check("ar_addr",  imem_addr, 32'h100);
        check("ar_valid", id_valid, 32'h0);
        check("ar_instr", id_instr, 32'h13);
        check("ar_pc",    id_pc, 32'h100);
        do_reset(1'b1);
        id_ready = 1'b1;
        lat      = 1;
        push_exp(32'h100);
        push_exp(32'h104);
        #1;
        check("ar_boot_req",   imem_req, 32'h0);
        check("ar_boot_valid", id_valid, 32'h0);
        at_cycle(1); #1;
        check("ar_req1",   imem_req, 32'h1);
        check("ar_addr1",  imem_addr, 32'h100);
        check("ar_valid1", id_valid, 32'h0);
        at_cycle(5);
        id_ready = 1'b0;
        #1;
        check("ar_drained", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
